// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings, default width
// and the full-adder carry function.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_adder.sv
// Single-bit full-adder cell; purely combinational.
module serial_subtractor_full_adder
    import serial_subtractor_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = majority(a, b, cin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, computed as a + ~b + ~bin through one
// full-adder cell with a registered carry. Results hold until the next completion.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_r;
    logic [WIDTH-1:0]   a_sh_r;
    logic [WIDTH-1:0]   b_sh_r;
    logic [WIDTH-1:0]   res_sh_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               carry_r;
    logic               nb_s;
    logic               sum_s;
    logic               cout_s;
    logic               last_s;
    logic [WIDTH-1:0]   res_next_s;

    assign nb_s       = ~b_sh_r[0];
    assign last_s     = (cnt_r == CNT_W'(WIDTH - 1));
    assign res_next_s = {sum_s, res_sh_r[WIDTH-1:1]};

    serial_subtractor_full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (nb_s),
        .cin  (carry_r),
        .sum  (sum_s),
        .cout (cout_s)
    );

    // FSM, operand/result shifters, carry, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_sh_r <= '0;
            cnt_r    <= '0;
            carry_r  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Inverted borrow-in seeds the carry of a + ~b + 1.
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        carry_r <= ~bin;
                        cnt_r   <= '0;
                        busy    <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_sh_r <= res_next_s;
                    carry_r  <= cout_s;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        // carry_r here is the carry into the MSB.
                        diff    <= res_next_s;
                        bout    <= ~cout_s;
                        ovf     <= carry_r ^ cout_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed plus exhaustive/randomized checks of serial_subtractor against an
// arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int acc = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: {ovf, bout, diff} from plain integer arithmetic.
    function automatic logic [W+1:0] ref_sub(input int x, input int y, input int bi);
        int d, sx, sy, sd;
        logic [W-1:0] dd;
        logic bo, ov;
        d  = x - y - bi;
        dd = W'(d & ((1 << W) - 1));
        bo = (x < y + bi);
        sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
        sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
        sd = sx - sy - bi;
        ov = (sd < -(1 << (W - 1))) || (sd > (1 << (W - 1)) - 1);
        return {ov, bo, dd};
    endfunction

    // Present an operation for one cycle, then scramble the operand inputs.
    task automatic start_op(input int x, input int y, input int bi);
        a = W'(x); b = W'(y); bin = bi[0]; start = 1'b1;
        @(negedge clk);
        acc = cyc;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    endtask

    // Wait (bounded) for done, then check latency and results.
    task automatic finish_op(input string tag, input int x, input int y, input int bi);
        logic [W+1:0] e;
        int n;
        e = ref_sub(x, y, bi);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(cyc - acc), 32'(W));
        check({tag, "_res"}, {ovf, bout, diff}, 32'(e));
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic full_op(input string tag, input int x, input int y, input int bi);
        start_op(x, y, bi);
        check({tag, "_busy1"}, 32'(busy), 32'd1);
        finish_op(tag, x, y, bi);
    endtask

    initial begin
        bit seen_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", {busy, done, ovf, bout, diff}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_hold", {busy, done}, 32'd0);

        full_op("t7m3", 7, 3, 0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("hold_diff", 32'(diff), 32'd4);
        full_op("t3m5", 3, 5, 0);
        full_op("t8m1", 8, 1, 0);
        full_op("t7mF", 7, 15, 0);
        full_op("t0m0b1", 0, 0, 1);
        full_op("t0m0b0", 0, 0, 0);

        // Start while busy is ignored.
        start_op(9, 2, 0);
        @(negedge clk);
        a = 4'd1; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        finish_op("ign", 9, 2, 0);

        // Back-to-back start taken in the DONE cycle.
        start_op(6, 6, 0);
        check("b2b_busy", {busy, done}, 32'd2);
        finish_op("b2b", 6, 6, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        start_op(5, 3, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {busy, done, ovf, bout, diff}, 32'd0);
        seen_done = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("rst_nodone", 32'(seen_done), 32'd0);

        // Exhaustive sweep with random idle gaps.
        for (int x = 0; x < (1 << W); x++) begin
            for (int y = 0; y < (1 << W); y++) begin
                for (int bi = 0; bi < 2; bi++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    start_op(x, y, bi);
                    finish_op("sweep", x, y, bi);
                end
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor computing diff = a - b - bin, one bit per clock, LSB first.
- Uses a single full-adder cell with a registered carry, in two's-complement form: a + ~b + ~bin.
- Area-lean counterpart to the combinational ripple adders; sits beside them in the arithmetic library.
- Start/done handshake, so it can sit on multi-cycle datapaths where the subtract latency is tolerable.

Parameters:
- WIDTH, 4, operand and result width in bits; must be >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- bin  input  1  borrow-in; captured on accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result valid from this cycle
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned)
- ovf  output  1  signed two's-complement overflow of the subtraction

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, busy=0, done=0, diff=0, bout=0, ovf=0. The bit counter, shift registers and carry register are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at edge k:
  - Latch a_sh=a, b_sh=b, carry=~bin, cnt=0.
  - Go to RUN; busy=1 from edge k.
- RUN, each edge:
  - s = a_sh[0] ^ ~b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], ~b_sh[0], carry).
  - Shift a_sh and b_sh right by 1.
  - Shift s into the MSB of res_sh (shift right).
  - cnt <= cnt+1.
  - On the edge processing bit WIDTH-1 (cnt=WIDTH-1):
    - diff <= final res_sh including this bit.
    - bout <= ~carry_out.
    - ovf <= carry_into_MSB ^ carry_out.
    - done <= 1, busy <= 0; go to DONE.
- Latency: done rises exactly WIDTH cycles after the accepting edge (edge k+WIDTH).
- DONE:
  - Lasts one cycle; done=1, busy=0; next state IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation); the state goes directly to RUN.
- Output holding: diff/bout/ovf update only at the completing edge. They hold the previous result through IDLE and RUN until the next completion.
- start while busy=1: ignored; operands are not re-sampled and the operation in progress is unaffected.
- Input changes on a/b/bin after acceptance: no effect.
- rst mid-RUN: aborts immediately to reset values; no done pulse. rst has priority over start in the same cycle.
- Counter width: $clog2(WIDTH) bits; no wrap is reachable because RUN exits at WIDTH-1.

Decomposition:
- Shared include file (arith_defs.vh) holds:
  - state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2);
  - default WIDTH.
- One sub-module: the existing full_adder cell, instantiated once. Inputs are a_sh[0], ~b_sh[0] and carry; its sum and cout feed the shift and carry registers.
- Everything else (FSM, counter, shift registers) stays flat in serial_subtractor.

Test Plan:
- WIDTH=4, a=7, b=3, bin=0, start 1 cycle -> busy 4 cycles; done at start edge+4; diff=4, bout=0, ovf=0.
- a=3, b=5, bin=0 -> diff=4'hE, bout=1, ovf=0.
- a=4'h8, b=1, bin=0 -> diff=4'h7, bout=0, ovf=1. Then a=4'h7, b=4'hF -> diff=4'h8, bout=1, ovf=1.
- a=0, b=0, bin=1 -> diff=4'hF, bout=1, ovf=0. Then a=0, b=0, bin=0 -> diff=0, bout=0, ovf=0.
- Busy and back-to-back starts:
  - Start 9-2; pulse start with 1-1 at cycle 2 of RUN -> ignored; diff=7.
  - Assert start with 6-6 in the DONE cycle -> accepted; next done 4 cycles later; diff=0.
- Reset mid-RUN and random sweep:
  - Assert rst at RUN cycle 2 -> next cycle busy=0, done=0, diff/bout/ovf=0; no done pulse follows.
  - Random exhaustive sweep of all a, b, bin for WIDTH=4 against a reference model.
